// File: rtl/mmio_rd_responder_if.sv
// MMIO read-responder bus bundle: request strobe, user lookup port,
// response channel toward Tx c2 and drop reporting.
// master = surrounding logic (request source, lookup RAM, Tx side);
// slave  = the responder itself.
interface mmio_rd_responder_if #(
  parameter int ADDR_W = 16,
  parameter int TID_W  = 9,
  parameter int DATA_W = 64
);
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [TID_W-1:0]  rd_req_tid;
  logic              lkup_valid;
  logic [ADDR_W-1:0] lkup_addr;
  logic [DATA_W-1:0] lkup_data;
  logic              resp_stall;
  logic              resp_valid;
  logic [TID_W-1:0]  resp_tid;
  logic [DATA_W-1:0] resp_data;
  logic              req_drop;
  logic [15:0]       drop_cnt;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_tid, lkup_data, resp_stall,
    input  lkup_valid, lkup_addr, resp_valid, resp_tid, resp_data, req_drop, drop_cnt
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_tid, lkup_data, resp_stall,
    output lkup_valid, lkup_addr, resp_valid, resp_tid, resp_data, req_drop, drop_cnt
  );
endinterface

// File: rtl/mmio_rd_responder.sv
// MMIO read-response stage for the ccip_mmio AFU.
// Answers DFH / AFU-ID CSRs locally, forwards user-range reads to a
// fixed-latency lookup port, and queues responses toward Tx c2 under a
// credit scheme (credit = requests in flight + queued responses).
// Optional build macro: MMIO_RD_RESP_COUNT_EN adds a 64-bit pop counter
// readable at address 0x0030 (takes precedence over the user range).
// The interface instance must use the same ADDR_W/TID_W/DATA_W values.
module mmio_rd_responder #(
  parameter int           ADDR_W     = 16,
  parameter int           TID_W      = 9,
  parameter int           DATA_W     = 64,
  parameter int           LAT        = 2,
  parameter int           QDEPTH     = 4,
  parameter logic [127:0] AFU_ID     = 128'h0,
  parameter logic [15:0]  USER_BASE  = 16'h0020,
  parameter logic [15:0]  USER_LIMIT = 16'h003F
) (
  input logic               clk,
  input logic               rst,
  mmio_rd_responder_if.slave bus
);

  localparam int          CNT_W   = $clog2(QDEPTH + 1);
  localparam int          PTR_W   = $clog2(QDEPTH);
  localparam logic [63:0] DFH_VAL = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

  // Classification / admission
  logic              accept_s;
  logic              cls_user_s;
  logic [DATA_W-1:0] cls_data_s;
  logic [CNT_W-1:0]  credit_r;
  // Fixed-latency pipeline, stage LAT lines up with lookup data
  logic [LAT:0]      pipe_v_r;
  logic              pipe_user_r [0:LAT];
  logic [TID_W-1:0]  pipe_tid_r  [0:LAT];
  logic [DATA_W-1:0] pipe_data_r [0:LAT];
  logic              push_s;
  logic [DATA_W-1:0] push_data_s;
  // Response queue; resp_*_r always mirror the queue head
  logic [TID_W-1:0]  q_tid_r  [0:QDEPTH-1];
  logic [DATA_W-1:0] q_data_r [0:QDEPTH-1];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [CNT_W-1:0]  q_cnt_r;
  logic [CNT_W-1:0]  q_cnt_nxt_s;
  logic [TID_W-1:0]  head_tid_s;
  logic [DATA_W-1:0] head_data_s;
  logic              pop_s;
  // Registered outputs
  logic              resp_valid_r;
  logic [TID_W-1:0]  resp_tid_r;
  logic [DATA_W-1:0] resp_data_r;
  logic              lkup_valid_r;
  logic [ADDR_W-1:0] lkup_addr_r;
  logic              req_drop_r;
  logic [15:0]       drop_cnt_r;
`ifdef MMIO_RD_RESP_COUNT_EN
  logic [63:0]       pop_cnt_r;
`endif

  assign accept_s = bus.rd_req_valid && (credit_r < CNT_W'(QDEPTH));
  assign pop_s    = resp_valid_r && !bus.resp_stall;
  assign push_s   = pipe_v_r[LAT];

  // Decode the request address into local data or a user lookup.
  always_comb begin
    cls_user_s = 1'b0;
    cls_data_s = '0;
    case (bus.rd_req_addr)
      ADDR_W'(16'h0000): cls_data_s = DATA_W'(DFH_VAL);
      ADDR_W'(16'h0002): cls_data_s = DATA_W'(AFU_ID[63:0]);
      ADDR_W'(16'h0004): cls_data_s = DATA_W'(AFU_ID[127:64]);
`ifdef MMIO_RD_RESP_COUNT_EN
      ADDR_W'(16'h0030): cls_data_s = DATA_W'(pop_cnt_r);
`endif
      default: begin
        if ((bus.rd_req_addr >= ADDR_W'(USER_BASE)) && (bus.rd_req_addr <= ADDR_W'(USER_LIMIT))) begin
          cls_user_s = 1'b1;
        end else begin
          cls_data_s = '0;
        end
      end
    endcase
  end

  // Credit counter: +1 per accepted request, -1 per popped response.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= '0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   credit_r <= credit_r + CNT_W'(1);
        2'b01:   credit_r <= credit_r - CNT_W'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  // Drop reporting and user lookup strobe, one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_drop_r   <= 1'b0;
      drop_cnt_r   <= 16'h0000;
      lkup_valid_r <= 1'b0;
      lkup_addr_r  <= '0;
    end else begin
      req_drop_r   <= bus.rd_req_valid && !accept_s;
      if (bus.rd_req_valid && !accept_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
      lkup_valid_r <= accept_s && cls_user_s;
      lkup_addr_r  <= (accept_s && cls_user_s) ? bus.rd_req_addr : '0;
    end
  end

  // Equal-latency pipeline for every class keeps responses in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v_r <= '0;
      for (int k = 0; k <= LAT; k++) begin
        pipe_user_r[k] <= 1'b0;
        pipe_tid_r[k]  <= '0;
        pipe_data_r[k] <= '0;
      end
    end else begin
      pipe_v_r       <= {pipe_v_r[LAT-1:0], accept_s};
      pipe_user_r[0] <= cls_user_s;
      pipe_tid_r[0]  <= bus.rd_req_tid;
      pipe_data_r[0] <= cls_data_s;
      for (int k = 1; k <= LAT; k++) begin
        pipe_user_r[k] <= pipe_user_r[k-1];
        pipe_tid_r[k]  <= pipe_tid_r[k-1];
        pipe_data_r[k] <= pipe_data_r[k-1];
      end
    end
  end

  // Select lookup data for user entries as they leave the pipeline.
  always_comb begin
    if (pipe_user_r[LAT]) begin
      push_data_s = bus.lkup_data;
    end else begin
      push_data_s = pipe_data_r[LAT];
    end
  end

  // Next queue occupancy, read pointer and head (bypass when the pushed
  // entry becomes the head in the same cycle).
  always_comb begin
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   q_cnt_nxt_s = q_cnt_r + CNT_W'(1);
      2'b01:   q_cnt_nxt_s = q_cnt_r - CNT_W'(1);
      default: q_cnt_nxt_s = q_cnt_r;
    endcase
    if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_tid_s  = pipe_tid_r[LAT];
      head_data_s = push_data_s;
    end else begin
      head_tid_s  = q_tid_r[rd_ptr_nxt_s];
      head_data_s = q_data_r[rd_ptr_nxt_s];
    end
  end

  // Circular response queue with registered head outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      q_cnt_r      <= '0;
      resp_valid_r <= 1'b0;
      resp_tid_r   <= '0;
      resp_data_r  <= '0;
      for (int k = 0; k < QDEPTH; k++) begin
        q_tid_r[k]  <= '0;
        q_data_r[k] <= '0;
      end
    end else begin
      if (push_s) begin
        q_tid_r[wr_ptr_r]  <= pipe_tid_r[LAT];
        q_data_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r     <= rd_ptr_nxt_s;
      q_cnt_r      <= q_cnt_nxt_s;
      resp_valid_r <= (q_cnt_nxt_s != '0);
      resp_tid_r   <= (q_cnt_nxt_s != '0) ? head_tid_s  : '0;
      resp_data_r  <= (q_cnt_nxt_s != '0) ? head_data_s : '0;
    end
  end

`ifdef MMIO_RD_RESP_COUNT_EN
  // Free-running count of popped responses, wraps at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt_r <= 64'h0;
    end else if (pop_s) begin
      pop_cnt_r <= pop_cnt_r + 64'h1;
    end
  end
`endif

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_tid   = resp_tid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.lkup_valid = lkup_valid_r;
  assign bus.lkup_addr  = lkup_addr_r;
  assign bus.req_drop   = req_drop_r;
  assign bus.drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_mmio_rd_responder.sv
// Directed testbench for mmio_rd_responder (LAT=2, QDEPTH=4).
// Honors MMIO_RD_RESP_COUNT_EN to pick the expected 0x0030 behaviour.
module tb_mmio_rd_responder;

  localparam logic [127:0] AFU_ID_T = 128'hA5A5_0123_4567_89AB_CDEF_0011_2233_445A;
  localparam logic [63:0]  AFU_LO   = 64'hCDEF_0011_2233_445A;
  localparam logic [63:0]  AFU_HI   = 64'hA5A5_0123_4567_89AB;
  localparam logic [63:0]  DFH_E    = 64'h1000_0100_0000_0000;
  localparam logic [63:0]  USR20_E  = 64'hDEADBEEF_CAFEF00D;

  logic        clk = 1'b0;
  logic        rst;
  int          vectors = 0;
  int          miscompares = 0;
  int          lkup_pulses = 0;
  int          drop_pulses = 0;
  int          base;
  logic        lv_d0, lv_d1;
  logic [15:0] la_d0, la_d1;

  mmio_rd_responder_if #(.ADDR_W(16), .TID_W(9), .DATA_W(64)) bus ();

  mmio_rd_responder #(
    .ADDR_W(16), .TID_W(9), .DATA_W(64), .LAT(2), .QDEPTH(4),
    .AFU_ID(AFU_ID_T), .USER_BASE(16'h0020), .USER_LIMIT(16'h003F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Lookup RAM model: returns data two cycles after lkup_valid.
  always @(posedge clk) begin
    if (rst) begin
      lv_d0 <= 1'b0; lv_d1 <= 1'b0; la_d0 <= 16'h0; la_d1 <= 16'h0;
    end else begin
      lv_d0 <= bus.lkup_valid; la_d0 <= bus.lkup_addr;
      lv_d1 <= lv_d0;          la_d1 <= la_d0;
    end
  end
  assign bus.lkup_data = !lv_d1 ? 64'h0 :
                         (la_d1 == 16'h0020) ? USR20_E : {48'h1234_0000_0000, la_d1};

  // Pulse counters for lkup_valid and req_drop.
  always @(negedge clk) begin
    if (bus.lkup_valid === 1'b1) lkup_pulses++;
    if (bus.req_drop === 1'b1) drop_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [15:0] a, input logic [8:0] t);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = a;
    bus.rd_req_tid   = t;
    tick();
    bus.rd_req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = 16'h0;
    bus.rd_req_tid   = 9'h0;
    bus.resp_stall   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_data",  bus.resp_data, 64'h0);
    chk("rst_lkup_valid", bus.lkup_valid, 1'b0);
    chk("rst_req_drop",   bus.req_drop, 1'b0);
    chk("rst_drop_cnt",   bus.drop_cnt, 16'h0);

    // AFU_ID low word, latency N+4
    req(16'h0002, 9'h005);
    chk("afu_lo_nolkup", bus.lkup_valid, 1'b0);
    tick(); tick();
    chk("afu_lo_early", bus.resp_valid, 1'b0);
    tick();
    chk("afu_lo_valid", bus.resp_valid, 1'b1);
    chk("afu_lo_tid",   bus.resp_tid, 9'h005);
    chk("afu_lo_data",  bus.resp_data, AFU_LO);
    tick();
    chk("afu_lo_done", bus.resp_valid, 1'b0);

    // User lookup
    req(16'h0020, 9'h011);
    chk("usr_lkup_valid", bus.lkup_valid, 1'b1);
    chk("usr_lkup_addr",  bus.lkup_addr, 16'h0020);
    tick(); tick();
    chk("usr_early", bus.resp_valid, 1'b0);
    tick();
    chk("usr_valid", bus.resp_valid, 1'b1);
    chk("usr_tid",   bus.resp_tid, 9'h011);
    chk("usr_data",  bus.resp_data, USR20_E);
    tick();

    // Overflow under stall: 6 requests, 4 accepted, 2 dropped
    base = drop_pulses;
    bus.resp_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.rd_req_valid = 1'b1;
      bus.rd_req_addr  = 16'h0000;
      bus.rd_req_tid   = 9'(9'h040 + i);
      tick();
      if (i == 3) chk("drop_none_yet", bus.req_drop, 1'b0);
      if (i == 4) chk("drop_pulse", bus.req_drop, 1'b1);
    end
    bus.rd_req_valid = 1'b0;
    repeat (4) tick();
    chk("drop_pulses", 64'(drop_pulses - base), 64'd2);
    chk("drop_cnt",    bus.drop_cnt, 16'd2);
    chk("stall_hold_tid", bus.resp_tid, 9'h040);
    bus.resp_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", bus.resp_valid, 1'b1);
      chk("drain_tid",   bus.resp_tid, 9'(9'h040 + i));
      chk("drain_data",  bus.resp_data, DFH_E);
      tick();
    end
    chk("drain_done", bus.resp_valid, 1'b0);

    // Interleaved classes stay in order
    base = lkup_pulses;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr = 16'h0000; bus.rd_req_tid = 9'h021; tick();
    bus.rd_req_addr = 16'h0022; bus.rd_req_tid = 9'h022; tick();
    bus.rd_req_addr = 16'h0100; bus.rd_req_tid = 9'h023; tick();
    bus.rd_req_addr = 16'h0004; bus.rd_req_tid = 9'h024; tick();
    bus.rd_req_valid = 1'b0;
    chk("mix0_tid", bus.resp_tid, 9'h021);
    chk("mix0_data", bus.resp_data, DFH_E);
    tick();
    chk("mix1_tid", bus.resp_tid, 9'h022);
    chk("mix1_data", bus.resp_data, 64'h1234_0000_0000_0022);
    tick();
    chk("mix2_tid", bus.resp_tid, 9'h023);
    chk("mix2_data", bus.resp_data, 64'h0);
    chk("mix2_valid", bus.resp_valid, 1'b1);
    tick();
    chk("mix3_tid", bus.resp_tid, 9'h024);
    chk("mix3_data", bus.resp_data, AFU_HI);
    tick();
    chk("mix_done", bus.resp_valid, 1'b0);
    chk("mix_lkup_once", 64'(lkup_pulses - base), 64'd1);

    // Reset with three responses queued
    bus.resp_stall = 1'b1;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req_tid = 9'(9'h050 + i);
      tick();
    end
    bus.rd_req_valid = 1'b0;
    repeat (5) tick();
    chk("prerst_valid", bus.resp_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_valid", bus.resp_valid, 1'b0);
    chk("midrst_drop_cnt", bus.drop_cnt, 16'h0);
    rst = 1'b0;
    bus.resp_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("postrst_no_stale", bus.resp_valid, 1'b0);
    end
    req(16'h0004, 9'h01A);
    tick(); tick(); tick();
    chk("fresh_valid", bus.resp_valid, 1'b1);
    chk("fresh_tid",   bus.resp_tid, 9'h01A);
    chk("fresh_data",  bus.resp_data, AFU_HI);
    tick();

    // Address 0x0030 after exactly three pops since reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req_tid = 9'(9'h060 + i);
      tick();
    end
    bus.rd_req_valid = 1'b0;
    repeat (6) tick();
    chk("cnt_pre_idle", bus.resp_valid, 1'b0);
    req(16'h0030, 9'h030);
`ifdef MMIO_RD_RESP_COUNT_EN
    chk("cnt_nolkup", bus.lkup_valid, 1'b0);
`else
    chk("a30_lkup_valid", bus.lkup_valid, 1'b1);
    chk("a30_lkup_addr",  bus.lkup_addr, 16'h0030);
`endif
    tick(); tick(); tick();
    chk("a30_valid", bus.resp_valid, 1'b1);
    chk("a30_tid",   bus.resp_tid, 9'h030);
`ifdef MMIO_RD_RESP_COUNT_EN
    chk("a30_data",  bus.resp_data, 64'd3);
`else
    chk("a30_data",  bus.resp_data, 64'h1234_0000_0000_0030);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
